// File: rtl/rvfi_order_gen_if.sv
// Retire-side and RVFI-side signal bundle for rvfi_order_gen.
// master drives retirements (core side); slave is the order generator.
interface rvfi_order_gen_if #(
    parameter int unsigned NRET    = 1,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ORDER_W = 64
);
    logic [NRET-1:0]         ret_valid;
    logic [32*NRET-1:0]      ret_insn;
    logic [XLEN*NRET-1:0]    ret_pc;
    logic [NRET-1:0]         ret_trap;
    logic [NRET-1:0]         ret_halt;
    logic                    trap_taken;

    logic [NRET-1:0]         rvfi_valid;
    logic [ORDER_W*NRET-1:0] rvfi_order;
    logic [32*NRET-1:0]      rvfi_insn;
    logic [XLEN*NRET-1:0]    rvfi_pc_rdata;
    logic [NRET-1:0]         rvfi_trap;
    logic [NRET-1:0]         rvfi_intr;
    logic [NRET-1:0]         rvfi_halt;
    logic                    halted;

    modport master (
        output ret_valid, ret_insn, ret_pc, ret_trap, ret_halt, trap_taken,
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata,
               rvfi_trap, rvfi_intr, rvfi_halt, halted
    );

    modport slave (
        input  ret_valid, ret_insn, ret_pc, ret_trap, ret_halt, trap_taken,
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_pc_rdata,
               rvfi_trap, rvfi_intr, rvfi_halt, halted
    );
endinterface

// File: rtl/rvfi_order_gen.sv
// RVFI producer: registers per-lane retirements and assigns consecutive rvfi_order values.
// Define RVFI_ORDER_COMPACT_EN to pack valid retirements onto channels 0..k-1.
module rvfi_order_gen #(
    parameter int unsigned NRET    = 1,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ORDER_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    rvfi_order_gen_if.slave  bus
);
    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    state_e                  state_q, state_d;
    logic [ORDER_W-1:0]      order_q, order_d;
    logic                    intr_pend_q, intr_pend_d;
    logic                    halted_q;

    logic [NRET-1:0]         valid_q, valid_d;
    logic [ORDER_W*NRET-1:0] ord_q, ord_d;
    logic [32*NRET-1:0]      insn_q, insn_d;
    logic [XLEN*NRET-1:0]    pc_q, pc_d;
    logic [NRET-1:0]         trap_q, trap_d;
    logic [NRET-1:0]         intr_q, intr_d;
    logic [NRET-1:0]         halt_q, halt_d;

    logic [NRET-1:0]         eff_valid;
    logic                    stop;
    int unsigned             cnt;
    int unsigned             ch;

    always_comb begin
        // Lanes above a halting lane (and everything once halted) never retire.
        eff_valid = '0;
        stop      = (state_q == HALTED);
        for (int unsigned i = 0; i < NRET; i++) begin
            if (bus.ret_valid[i] && !stop) begin
                eff_valid[i] = 1'b1;
                stop         = bus.ret_halt[i];
            end
        end

        valid_d = '0;
        ord_d   = '0;
        intr_d  = '0;
        insn_d  = insn_q;
        pc_d    = pc_q;
        trap_d  = trap_q;
        halt_d  = halt_q;
        cnt     = 0;
        ch      = 0;
        for (int unsigned i = 0; i < NRET; i++) begin
            if (eff_valid[i]) begin
`ifdef RVFI_ORDER_COMPACT_EN
                ch = cnt;
`else
                ch = i;
`endif
                valid_d[ch]                  = 1'b1;
                ord_d[ch*ORDER_W +: ORDER_W] = order_q + ORDER_W'(cnt);
                insn_d[ch*32 +: 32]          = bus.ret_insn[i*32 +: 32];
                pc_d[ch*XLEN +: XLEN]        = bus.ret_pc[i*XLEN +: XLEN];
                trap_d[ch]                   = bus.ret_trap[i];
                halt_d[ch]                   = bus.ret_halt[i];
                intr_d[ch]                   = intr_pend_q && (cnt == 0);
                cnt                          = cnt + 1;
            end
        end
        order_d = order_q + ORDER_W'(cnt);

        // A pending flag is consumed by the first retirement; a trap in that same
        // cycle is not re-armed, matching "one flag per pending trap".
        if (intr_pend_q) begin
            intr_pend_d = (cnt == 0);
        end else begin
            intr_pend_d = bus.trap_taken;
        end

        state_d = state_q;
        if ((eff_valid & bus.ret_halt) != '0) begin
            state_d = HALTED;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            order_q     <= '0;
            intr_pend_q <= 1'b0;
            halted_q    <= 1'b0;
            valid_q     <= '0;
            ord_q       <= '0;
            insn_q      <= '0;
            pc_q        <= '0;
            trap_q      <= '0;
            intr_q      <= '0;
            halt_q      <= '0;
        end else begin
            state_q     <= state_d;
            order_q     <= order_d;
            intr_pend_q <= intr_pend_d;
            halted_q    <= (state_q == HALTED);
            valid_q     <= valid_d;
            ord_q       <= ord_d;
            insn_q      <= insn_d;
            pc_q        <= pc_d;
            trap_q      <= trap_d;
            intr_q      <= intr_d;
            halt_q      <= halt_d;
        end
    end

    assign bus.rvfi_valid    = valid_q;
    assign bus.rvfi_order    = ord_q;
    assign bus.rvfi_insn     = insn_q;
    assign bus.rvfi_pc_rdata = pc_q;
    assign bus.rvfi_trap     = trap_q;
    assign bus.rvfi_intr     = intr_q;
    assign bus.rvfi_halt     = halt_q;
    assign bus.halted        = halted_q;
endmodule

// File: tb/tb_rvfi_order_gen.sv
// Scoreboard bench for rvfi_order_gen with NRET=2: a 64-bit order instance and a
// 3-bit order instance share stimulus so the narrow one exercises counter wrap.
module tb_rvfi_order_gen;
`ifdef RVFI_ORDER_COMPACT_EN
    localparam bit COMPACT = 1'b1;
`else
    localparam bit COMPACT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int          checks;
    int          errors;

    rvfi_order_gen_if #(.NRET(2), .XLEN(32), .ORDER_W(64)) wif ();
    rvfi_order_gen_if #(.NRET(2), .XLEN(32), .ORDER_W(3))  nif ();

    rvfi_order_gen #(.NRET(2), .XLEN(32), .ORDER_W(64)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (wif)
    );

    rvfi_order_gen #(.NRET(2), .XLEN(32), .ORDER_W(3)) dut_n (
        .clock (clk),
        .reset (rst),
        .bus   (nif)
    );

    typedef struct packed {
        int unsigned     cyc;
        logic [1:0]      valid;
        logic [1:0][63:0] ord;
        logic [1:0][31:0] insn;
        logic [1:0][31:0] pc;
        logic [1:0]      trap;
        logic [1:0]      intr;
        logic [1:0]      halt;
        logic            halted;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Inputs applied 1ns after a posedge; expected outputs become visible after the next edge.
    task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] tr,
                         input logic [1:0] hl, input logic tt,
                         input logic [1:0] ev, input logic [63:0] eo0, input logic [63:0] eo1,
                         input logic [1:0] ei, input logic eh);
        exp_t        e;
        logic [63:0] insn;
        logic [63:0] pc;
        int unsigned k;
        int unsigned c;
        logic        stop;
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            insn[l*32 +: 32] = 32'h1000_0000 + (cyc << 4) + 32'(l);
            pc[l*32 +: 32]   = 32'h8000_0000 + (cyc << 3) + 32'(l * 4);
        end
        rst = r;
        wif.ret_valid = v;  nif.ret_valid = v;
        wif.ret_trap  = tr; nif.ret_trap  = tr;
        wif.ret_halt  = hl; nif.ret_halt  = hl;
        wif.trap_taken = tt; nif.trap_taken = tt;
        wif.ret_insn  = insn; nif.ret_insn = insn;
        wif.ret_pc    = pc;   nif.ret_pc   = pc;

        e        = '0;
        e.cyc    = cyc + 1;
        e.valid  = ev;
        e.ord[0] = eo0;
        e.ord[1] = eo1;
        e.intr   = ei;
        e.halted = eh;
        k    = 0;
        stop = 1'b0;
        for (int l = 0; l < 2; l++) begin
            if (v[l] && !stop) begin
                c = COMPACT ? k : 32'(l);
                e.insn[c] = insn[l*32 +: 32];
                e.pc[c]   = pc[l*32 +: 32];
                e.trap[c] = tr[l];
                e.halt[c] = hl[l];
                stop = hl[l];
                k = k + 1;
            end
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("stale_expect", 64'(cyc), 64'(e.cyc));
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("valid",    64'(wif.rvfi_valid), 64'(e.valid));
            chk("halted",   64'(wif.halted),     64'(e.halted));
            chk("n_valid",  64'(nif.rvfi_valid), 64'(e.valid));
            chk("n_halted", 64'(nif.halted),     64'(e.halted));
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("order%0d", c), wif.rvfi_order[c*64 +: 64], e.ord[c]);
                chk($sformatf("n_order%0d", c), 64'(nif.rvfi_order[c*3 +: 3]), 64'(e.ord[c][2:0]));
                if (e.valid[c]) begin
                    chk($sformatf("insn%0d", c), 64'(wif.rvfi_insn[c*32 +: 32]),     64'(e.insn[c]));
                    chk($sformatf("pc%0d", c),   64'(wif.rvfi_pc_rdata[c*32 +: 32]), 64'(e.pc[c]));
                    chk($sformatf("trap%0d", c), 64'(wif.rvfi_trap[c]), 64'(e.trap[c]));
                    chk($sformatf("halt%0d", c), 64'(wif.rvfi_halt[c]), 64'(e.halt[c]));
                    chk($sformatf("intr%0d", c), 64'(wif.rvfi_intr[c]), 64'(e.intr[c]));
                end
            end
        end
    end

    initial begin
        int unsigned budget;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        wif.ret_valid = '0; nif.ret_valid = '0;
        wif.ret_trap  = '0; nif.ret_trap  = '0;
        wif.ret_halt  = '0; nif.ret_halt  = '0;
        wif.trap_taken = 1'b0; nif.trap_taken = 1'b0;
        wif.ret_insn  = '0; nif.ret_insn = '0;
        wif.ret_pc    = '0; nif.ret_pc   = '0;

        //     rst   valid  trap   halt   tt    exp_v  ord0  ord1  intr   halted
        drive(1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 0,    0,    2'b00, 1'b0);
        drive(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 0,    1,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 2,    3,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 4,    5,    2'b00, 1'b0);
        drive(1'b0, 2'b10, 2'b00, 2'b00, 1'b0, COMPACT ? 2'b01 : 2'b10,
              COMPACT ? 64'd6 : 64'd0, COMPACT ? 64'd0 : 64'd6, 2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 7,    8,    2'b00, 1'b0);
        drive(1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 9,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 10,   11,   2'b01, 1'b0);
        drive(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 0,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 0,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b10, 2'b00, 2'b00, 1'b0, COMPACT ? 2'b01 : 2'b10,
              COMPACT ? 64'd12 : 64'd0, COMPACT ? 64'd0 : 64'd12,
              COMPACT ? 2'b01 : 2'b10, 1'b0);
        drive(1'b0, 2'b11, 2'b10, 2'b00, 1'b0, 2'b11, 13,   14,   2'b00, 1'b0);
        drive(1'b0, 2'b01, 2'b00, 2'b10, 1'b0, 2'b01, 15,   0,    2'b00, 1'b0);
        drive(1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 0,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 0,    1,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 2'b01, 2,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 0,    0,    2'b00, 1'b1);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 0,    0,    2'b00, 1'b1);
        drive(1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 0,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 0,    1,    2'b00, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 2'b11, 2,    3,    2'b00, 1'b0);
        drive(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 0,    0,    2'b00, 1'b1);
        drive(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 0,    0,    2'b00, 1'b0);
        drive(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 0,    0,    2'b00, 1'b1);

        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget = budget + 1;
        end
        if (sb.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
